// File: rtl/solver_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the solver run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package solver_ctrl_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_X       = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd3;
  localparam logic [2:0] ADDR_CYCLES  = 3'd4;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} run_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/solver_run_ctrl_if.sv
// Avalon-MM slave bus plus level interrupt between the CPU and the run controller.
// Latency: n/a (wiring only); readdata is registered by the slave, 1 cycle.
// Backpressure: none, the slave accepts every access (no waitrequest).
interface solver_run_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (output address, write, writedata, read, input readdata, irq);
  modport slave  (input address, write, writedata, read, output readdata, irq);
endinterface

// File: rtl/solver_run_watchdog.sv
// Saturating run-length counter with a programmable expiry compare.
// Latency: count updates 1 cycle after en/clr; expire is combinational from count/limit.
// Backpressure: none.
module solver_run_watchdog
  import solver_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] limit,
  output logic [31:0] count,
  output logic        expire
);

  // Counter: clear wins over count, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

  // Expires on the cycle whose post-increment count would equal limit; limit 0 disables,
  // and a saturated counter can never match.
  assign expire = (limit != 32'd0) && (count != 32'hFFFF_FFFF) && (sat_inc(count) == limit);

endmodule

// File: rtl/solver_run_ctrl.sv
// Avalon-MM run controller: START launches the solver, waits for done under a watchdog, captures x.
// Latency: solver_start 1 cycle after the START write; readdata 1 cycle after address; irq 1 cycle after flag.
// Backpressure: none, every bus access is accepted; solver_done is only observed while waiting.
module solver_run_ctrl
  import solver_ctrl_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1000000
) (
  input  logic              clk,
  input  logic              reset,
  solver_run_ctrl_if.slave  bus,
  output logic              solver_start,
  input  logic              solver_done,
  input  logic [DATA_W-1:0] solver_x
);

  run_state_e        state_q, state_d;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] rd_mux, readdata_q;
  logic [31:0]       timeout_q, cycles_q, count;
  logic              irq_en_q, done_q, to_q, irq_q;
  logic              expire, busy;
  logic              wr_ctrl, wr_status, wr_timeout, start_req, abort_req;
  logic              run_clr, run_en, hit_done, hit_to;
  logic              unused_read;

  // Reads have no side effects, so the strobe is not needed.
  assign unused_read = bus.read;

  assign wr_ctrl    = bus.write && (bus.address == ADDR_CTRL);
  assign wr_status  = bus.write && (bus.address == ADDR_STATUS);
  assign wr_timeout = bus.write && (bus.address == ADDR_TIMEOUT);
  assign start_req  = wr_ctrl && bus.writedata[CTRL_START];
  assign abort_req  = wr_ctrl && bus.writedata[CTRL_ABORT];
  assign busy       = (state_q != IDLE);

  solver_run_watchdog u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (run_clr),
    .en     (run_en),
    .limit  (timeout_q),
    .count  (count),
    .expire (expire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and run events; within WAIT done beats timeout beats abort.
  always_comb begin
    state_d      = state_q;
    run_clr      = 1'b0;
    run_en       = 1'b0;
    solver_start = 1'b0;
    hit_done     = 1'b0;
    hit_to       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          run_clr = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        solver_start = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        run_en = 1'b1;
        if (solver_done) begin
          hit_done = 1'b1;
          state_d  = IDLE;
        end else if (expire) begin
          hit_to  = 1'b1;
          state_d = IDLE;
        end else if (abort_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Software-visible registers; a hardware flag set beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      cycles_q  <= '0;
      timeout_q <= TIMEOUT_DEFAULT;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (hit_done) begin
        x_q      <= solver_x;
        cycles_q <= sat_inc(count);
      end else if (hit_to) begin
        cycles_q <= timeout_q;
      end
      if (wr_ctrl)    irq_en_q  <= bus.writedata[CTRL_IRQ_EN];
      if (wr_timeout) timeout_q <= bus.writedata[31:0];
      if (hit_done)                                  done_q <= 1'b1;
      else if (wr_status && bus.writedata[STAT_DONE]) done_q <= 1'b0;
      if (hit_to)                                       to_q <= 1'b1;
      else if (wr_status && bus.writedata[STAT_TIMEOUT]) to_q <= 1'b0;
      irq_q <= irq_en_q & (done_q | to_q);
    end
  end

  // Read mux; unmapped addresses and bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_X:       rd_mux = x_q;
      ADDR_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = done_q;
        rd_mux[STAT_TIMEOUT] = to_q;
      end
      ADDR_TIMEOUT: rd_mux = DATA_W'(timeout_q);
      ADDR_CYCLES:  rd_mux = DATA_W'(cycles_q);
      default:      rd_mux = '0;
    endcase
  end

  // Read data register, refreshed every cycle regardless of the read strobe.
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= rd_mux;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule
